// File: rtl/stim_pkg.sv
// Shared encodings for the stimulus generator: FSM states, run modes,
// the operand source that drives o_ia/o_ib, and corner-table indexing.
package stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CORNER = 3'd1,
    ST_RANDOM = 3'd2,
    ST_WALK   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_CORNER = 2'b00,
    MODE_RANDOM = 2'b01,
    MODE_MIXED  = 2'b10,
    MODE_WALK   = 2'b11
  } mode_t;

  // Which generator currently feeds the operand outputs; it is kept after
  // a run ends so the last vector stays visible in DONE/IDLE.
  typedef enum logic [1:0] {
    SRC_CORNER = 2'd0,
    SRC_RANDOM = 2'd1,
    SRC_WALK   = 2'd2
  } src_t;

  localparam int CIDX_W      = 3;
  localparam int CORNER_LAST = 7;

endpackage

// File: rtl/stim_lfsr.sv
// Galois LFSR with synchronous load and step. A zero load is replaced by 1
// so the register can never lock up in the all-zero state.
module stim_lfsr #(
  parameter int             WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h80200003)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  // Next value: load wins over step; stepping shifts right and folds in TAPS
  // whenever a one falls out of the LSB.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? ONE : seed;
    end else if (step) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end
  end

  // State register; reset seeds the register with 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= ONE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/stim_gen.sv
// Stimulus generator: issues operand pairs (corner table, LFSR random,
// walking ones) one per cycle for a requested count, honours stalls and
// can abort on a downstream mismatch.
module stim_gen
  import stim_pkg::*;
#(
  parameter int             WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h80200003)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [15:0]      i_count,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_hold,
  input  logic             i_event,
  input  logic             i_stop_on_err,
  output logic [WIDTH-1:0] o_ia,
  output logic [WIDTH-1:0] o_ib,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [15:0]      o_vec_idx
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0]  ALL1      = '1;
  localparam logic [WIDTH-1:0]  MSB       = ONE << (WIDTH - 1);
  localparam logic [KW-1:0]     WALK_LAST = KW'(WIDTH - 1);
  localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(CORNER_LAST);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  src_t              src_q, src_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       vec_idx_q, vec_idx_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [CIDX_W-1:0] cidx_q, cidx_d;
  logic [KW-1:0]     walk_q, walk_d;

  logic             lfsr_load;
  logic             lfsr_step;
  logic [WIDTH-1:0] lfsr_a_q;
  logic [WIDTH-1:0] lfsr_b_q;
  logic             start_ok;
  logic             running;

  stim_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr_a (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (i_seed),
    .step  (lfsr_step),
    .q     (lfsr_a_q)
  );

  stim_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr_b (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (~i_seed),
    .step  (lfsr_step),
    .q     (lfsr_b_q)
  );

  assign start_ok = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign running  = (state_q == ST_CORNER) || (state_q == ST_RANDOM) || (state_q == ST_WALK);

  // Next-state logic: the generator pointers always name the vector on the
  // outputs, so issuing a vector means advancing a pointer at the clock edge.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    src_d     = src_q;
    count_d   = count_q;
    vec_idx_d = vec_idx_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    cidx_d    = cidx_q;
    walk_d    = walk_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    if (start_ok) begin
      err_d = 1'b0;
    end
    if (i_event && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          vec_idx_d = '0;
          count_d   = i_count;
          mode_d    = mode_t'(i_mode);
          if (i_count == '0) begin
            // An empty run leaves the generators alone so the held
            // operands do not change while o_valid stays low.
            state_d = ST_DONE;
          end else begin
            lfsr_load = 1'b1;
            cidx_d    = '0;
            walk_d    = '0;
            vec_idx_d = 16'd1;
            valid_d   = 1'b1;
            case (mode_t'(i_mode))
              MODE_RANDOM: begin
                state_d = ST_RANDOM;
                src_d   = SRC_RANDOM;
              end
              MODE_WALK: begin
                state_d = ST_WALK;
                src_d   = SRC_WALK;
              end
              default: begin
                state_d = ST_CORNER;
                src_d   = SRC_CORNER;
              end
            endcase
          end
        end
      end

      ST_CORNER, ST_RANDOM, ST_WALK: begin
        if (!i_hold) begin
          if (i_event && i_stop_on_err) begin
            state_d = ST_DONE;
          end else if (vec_idx_q == count_q) begin
            state_d = ST_DONE;
          end else begin
            valid_d   = 1'b1;
            vec_idx_d = vec_idx_q + 16'd1;
            case (state_q)
              ST_CORNER: begin
                if ((cidx_q == CIDX_LAST) && (mode_q == MODE_MIXED)) begin
                  // The LFSRs still hold their seeds, so the first random
                  // vector is shown without stepping.
                  state_d = ST_RANDOM;
                  src_d   = SRC_RANDOM;
                end else begin
                  cidx_d = cidx_q + CIDX_W'(1);
                end
              end
              ST_RANDOM: begin
                lfsr_step = 1'b1;
              end
              default: begin
                walk_d = (walk_q == WALK_LAST) ? '0 : walk_q + KW'(1);
              end
            endcase
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and pointer registers; reset returns to IDLE with a zero vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_CORNER;
      src_q     <= SRC_CORNER;
      count_q   <= '0;
      vec_idx_q <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      cidx_q    <= '0;
      walk_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      count_q   <= count_d;
      vec_idx_q <= vec_idx_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      cidx_q    <= cidx_d;
      walk_q    <= walk_d;
    end
  end

  // Operand mux from the registered pointers; corner entry 0 is all zeros,
  // which is what the outputs show straight out of reset.
  always_comb begin
    o_ia = '0;
    o_ib = '0;
    case (src_q)
      SRC_CORNER: begin
        case (cidx_q)
          3'd0:    begin o_ia = '0;   o_ib = '0;   end
          3'd1:    begin o_ia = '0;   o_ib = ALL1; end
          3'd2:    begin o_ia = ALL1; o_ib = '0;   end
          3'd3:    begin o_ia = ALL1; o_ib = ALL1; end
          3'd4:    begin o_ia = ONE;  o_ib = ALL1; end
          3'd5:    begin o_ia = ALL1; o_ib = ONE;  end
          3'd6:    begin o_ia = MSB;  o_ib = MSB;  end
          default: begin o_ia = ~MSB; o_ib = ONE;  end
        endcase
      end
      SRC_RANDOM: begin
        o_ia = lfsr_a_q;
        o_ib = lfsr_b_q;
      end
      SRC_WALK: begin
        o_ia = ONE << walk_q;
        o_ib = ~(ONE << walk_q);
      end
      default: begin
        o_ia = '0;
        o_ib = '0;
      end
    endcase
  end

  assign o_valid   = valid_q;
  assign o_busy    = running;
  assign o_done    = (state_q == ST_DONE);
  assign o_err     = err_q;
  assign o_vec_idx = vec_idx_q;

endmodule

// File: tb/tb_stim_gen.sv
// Directed bench for stim_gen: each run's valid vectors are collected and
// compared against hand-computed tables.
module tb_stim_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [1:0]  i_mode;
  logic [15:0] i_count;
  logic [31:0] i_seed;
  logic        i_hold;
  logic        i_event;
  logic        i_stop_on_err;
  logic [31:0] o_ia;
  logic [31:0] o_ib;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [15:0] o_vec_idx;

  int checks = 0;
  int errors = 0;

  logic        collect = 1'b0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  logic [31:0] cornerA[8] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
  logic [31:0] cornerB[8] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h1};
  // LFSR sequences for seed 0 (A substituted to 1, B = all ones), TAPS 80200003.
  logic [31:0] rndA[5] = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001, 32'hB02C0003};
  logic [31:0] rndB[4] = '{32'hFFFFFFFF, 32'hFFDFFFFC, 32'h7FEFFFFE, 32'h3FF7FFFF};

  stim_gen dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_mode        (i_mode),
    .i_count       (i_count),
    .i_seed        (i_seed),
    .i_hold        (i_hold),
    .i_event       (i_event),
    .i_stop_on_err (i_stop_on_err),
    .o_ia          (o_ia),
    .o_ib          (o_ib),
    .o_valid       (o_valid),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_vec_idx     (o_vec_idx)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Record every valid vector on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (collect && o_valid) begin
      qa.push_back(o_ia);
      qb.push_back(o_ib);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse i_start for one clock; returns #1 after the first vector cycle.
  task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] count, input logic [31:0] seed);
    @(negedge clk);
    qa.delete();
    qb.delete();
    i_mode  = mode;
    i_count = count;
    i_seed  = seed;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    #1;
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (!o_done && cycles < budget) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    if (!o_done) checkOutput("done_timeout", 64'(o_done), 64'd1);
  endtask

  task automatic waitVectors(input int n, input int budget);
    int c = 0;
    while (qa.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (qa.size() < n) checkOutput("vector_timeout", 64'(qa.size()), 64'(n));
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    i_start = 1'b0;
    i_mode = 2'b00;
    i_count = '0;
    i_seed = '0;
    i_hold = 1'b0;
    i_event = 1'b0;
    i_stop_on_err = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_ia", 64'(o_ia), 64'd0);
    checkOutput("rst_ib", 64'(o_ib), 64'd0);
    checkOutput("rst_ctl", 64'({o_valid, o_busy, o_done, o_err}), 64'd0);
    checkOutput("rst_idx", 64'(o_vec_idx), 64'd0);
    reset = 1'b0;
    collect = 1'b1;

    // Mode 00, count 10: table 0..7 then 0,1; done at cycle 11.
    applyStimulus(2'b00, 16'd10, 32'h0);
    checkOutput("m00_busy", 64'(o_busy), 64'd1);
    waitDone(50, cyc);
    checkOutput("m00_done_cycle", 64'(cyc + 1), 64'd11);
    checkOutput("m00_nvalid", 64'(qa.size()), 64'd10);
    checkOutput("m00_idx", 64'(o_vec_idx), 64'd10);
    checkOutput("m00_valid_done", 64'(o_valid), 64'd0);
    for (int i = 0; i < 10 && i < qa.size(); i++) begin
      checkOutput($sformatf("m00_a%0d", i), 64'(qa[i]), 64'(cornerA[i % 8]));
      checkOutput($sformatf("m00_b%0d", i), 64'(qb[i]), 64'(cornerB[i % 8]));
    end

    // Mode 01, seed 0 (A substituted with 1), count 3.
    applyStimulus(2'b01, 16'd3, 32'h0);
    waitDone(20, cyc);
    checkOutput("m01_nvalid", 64'(qa.size()), 64'd3);
    for (int i = 0; i < 3 && i < qa.size(); i++) begin
      checkOutput($sformatf("m01_a%0d", i), 64'(qa[i]), 64'(rndA[i]));
      checkOutput($sformatf("m01_b%0d", i), 64'(qb[i]), 64'(rndB[i]));
    end

    // Mode 11, count 34; a start during the run is ignored, an event without
    // stop-on-error only sets the sticky flag.
    applyStimulus(2'b11, 16'd34, 32'h0);
    repeat (3) @(negedge clk);
    i_start = 1'b1;
    i_mode  = 2'b00;
    i_count = 16'd1;
    i_event = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_event = 1'b0;
    #1;
    checkOutput("walk_busy_after_start", 64'(o_busy), 64'd1);
    checkOutput("walk_err_sticky", 64'(o_err), 64'd1);
    waitDone(100, cyc);
    checkOutput("walk_nvalid", 64'(qa.size()), 64'd34);
    checkOutput("walk_err_done", 64'(o_err), 64'd1);
    for (int i = 0; i < 34 && i < qa.size(); i++) begin
      checkOutput($sformatf("walk_a%0d", i), 64'(qa[i]), 64'(32'h1 << (i % 32)));
    end
    if (qa.size() >= 33) begin
      checkOutput("walk_v33_a", 64'(qa[32]), 64'h1);
      checkOutput("walk_v33_b", 64'(qb[32]), 64'hFFFFFFFE);
    end

    // Mode 10, count 12, hold for three cycles after the fifth vector.
    applyStimulus(2'b10, 16'd12, 32'h0);
    checkOutput("mix_err_cleared", 64'(o_err), 64'd0);
    waitVectors(5, 20);
    i_hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("hold%0d_valid", h), 64'(o_valid), 64'd0);
      checkOutput($sformatf("hold%0d_ia", h), 64'(o_ia), 64'h1);
      checkOutput($sformatf("hold%0d_idx", h), 64'(o_vec_idx), 64'd5);
    end
    i_hold = 1'b0;
    waitDone(50, cyc);
    checkOutput("mix_nvalid", 64'(qa.size()), 64'd12);
    for (int i = 0; i < 12 && i < qa.size(); i++) begin
      checkOutput($sformatf("mix_a%0d", i), 64'(qa[i]), 64'((i < 8) ? cornerA[i] : rndA[i - 8]));
      checkOutput($sformatf("mix_b%0d", i), 64'(qb[i]), 64'((i < 8) ? cornerB[i] : rndB[i - 8]));
    end

    // Count 0 goes straight to DONE.
    applyStimulus(2'b01, 16'd0, 32'h5);
    checkOutput("cnt0_done", 64'(o_done), 64'd1);
    checkOutput("cnt0_valid", 64'(o_valid), 64'd0);
    checkOutput("cnt0_idx", 64'(o_vec_idx), 64'd0);

    // Mode 10 with count 5 ends inside the corner table.
    applyStimulus(2'b10, 16'd5, 32'h0);
    waitDone(20, cyc);
    checkOutput("short_nvalid", 64'(qa.size()), 64'd5);
    checkOutput("short_hold_ia", 64'(o_ia), 64'h1);
    checkOutput("short_hold_ib", 64'(o_ib), 64'hFFFFFFFF);

    // Stop on error: event during the fifth vector aborts the run.
    i_stop_on_err = 1'b1;
    applyStimulus(2'b01, 16'd20, 32'h0);
    waitVectors(5, 20);
    i_event = 1'b1;
    @(negedge clk);
    i_event = 1'b0;
    #1;
    checkOutput("abort_done", 64'(o_done), 64'd1);
    checkOutput("abort_err", 64'(o_err), 64'd1);
    checkOutput("abort_idx", 64'(o_vec_idx), 64'd5);
    checkOutput("abort_ia_held", 64'(o_ia), 64'(rndA[4]));
    checkOutput("abort_nvalid", 64'(qa.size()), 64'd5);

    // Event on the last vector: DONE once with the error flag set.
    applyStimulus(2'b00, 16'd3, 32'h0);
    waitVectors(3, 20);
    i_event = 1'b1;
    @(negedge clk);
    i_event = 1'b0;
    #1;
    checkOutput("last_done", 64'(o_done), 64'd1);
    checkOutput("last_err", 64'(o_err), 64'd1);
    checkOutput("last_idx", 64'(o_vec_idx), 64'd3);
    @(negedge clk);
    #1;
    checkOutput("last_done_stable", 64'({o_done, o_valid, o_busy}), 64'b100);
    checkOutput("last_nvalid", 64'(qa.size()), 64'd3);
    i_stop_on_err = 1'b0;

    // Reset in the middle of a walk run with the error flag set.
    applyStimulus(2'b11, 16'd20, 32'h0);
    i_event = 1'b1;
    @(negedge clk);
    i_event = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("mid_pre_busy", 64'({o_busy, o_err}), 64'b11);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_ia", 64'(o_ia), 64'd0);
    checkOutput("mid_rst_ib", 64'(o_ib), 64'd0);
    checkOutput("mid_rst_ctl", 64'({o_valid, o_busy, o_done, o_err}), 64'd0);
    checkOutput("mid_rst_idx", 64'(o_vec_idx), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("post_rst_idle", 64'({o_valid, o_busy, o_done}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
